// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic instruction requests into MIPS words and drains them through an IM write port.
// Optional delay-slot nop padding after branches/jumps is enabled by defining ENC_DSLOT_PAD_EN.
module instr_encoder #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 op_sel,
    input  logic [4:0]                 rs,
    input  logic [4:0]                 rt,
    input  logic [4:0]                 rd,
    input  logic [15:0]                imm,
    input  logic [25:0]                target,
    output logic                       im_we,
    input  logic                       im_ready,
    output logic [ADDR_W-1:0]          im_addr,
    output logic [31:0]                im_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_PAD  = 1'b1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]       mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              state_q, state_d;
    logic [31:0]       word, push_word;
    logic              legal, full, accept, push, pop, pad_push;

    always_comb begin
        word = '0;
        case (op_sel)
            5'd1:  word = {6'h00, rs, rt, rd, 5'd0, 6'h21};
            5'd2:  word = {6'h00, rs, rt, rd, 5'd0, 6'h23};
            5'd3:  word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            5'd4:  word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            5'd5:  word = {6'h0D, rs, rt, imm};
            5'd6:  word = {6'h0F, 5'd0, rt, imm};
            5'd7:  word = {6'h23, rs, rt, imm};
            5'd8:  word = {6'h2B, rs, rt, imm};
            5'd9:  word = {6'h21, rs, rt, imm};
            5'd10: word = {6'h25, rs, rt, imm};
            5'd11: word = {6'h20, rs, rt, imm};
            5'd12: word = {6'h24, rs, rt, imm};
            5'd13: word = {6'h29, rs, rt, imm};
            5'd14: word = {6'h28, rs, rt, imm};
            5'd15: word = {6'h04, rs, rt, imm};
            5'd16: word = {6'h05, rs, rt, imm};
            5'd17: word = {6'h02, target};
            5'd18: word = {6'h03, target};
            5'd19: word = {6'h00, rs, 15'd0, 6'h08};
            5'd20: word = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
            5'd21: word = {6'h07, rs, 5'd0, imm};
            5'd22: word = {6'h06, rs, 5'd0, imm};
            5'd23: word = {6'h01, rs, 5'd0, imm};
            5'd24: word = {6'h01, rs, 5'd1, imm};
            default: word = '0;
        endcase
    end

    assign legal    = op_sel <= 5'd24;
    assign full     = cnt_q == FULL;
    assign in_ready = !full && state_q == S_IDLE && !flush;
    assign accept   = in_valid && in_ready;
    assign pop      = im_we && im_ready && !flush;

`ifdef ENC_DSLOT_PAD_EN
    // PAD holds off new requests until the delay-slot nop fits in the FIFO
    assign pad_push = state_q == S_PAD && !full && !flush;
    assign state_d  = flush ? S_IDLE :
                      state_q == S_PAD ? (full ? S_PAD : S_IDLE) :
                      (accept && legal && op_sel >= 5'd15) ? S_PAD : S_IDLE;
`else
    assign pad_push = 1'b0;
    assign state_d  = S_IDLE;
`endif

    assign push      = (accept && legal) || pad_push;
    assign push_word = pad_push ? 32'h0 : word;
    assign wr_d      = flush ? '0 : push ? wr_q + PW'(1) : wr_q;
    assign rd_d      = flush ? '0 : pop ? rd_q + PW'(1) : rd_q;
    assign cnt_d     = flush ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    assign addr_d    = flush ? BASE : pop ? addr_q + ADDR_W'(1) : addr_q;
    assign err_d     = accept && !legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= BASE;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_word;
    end

    assign im_we    = cnt_q != '0;
    assign im_wdata = mem_q[rd_q];
    assign im_addr  = addr_q;
    assign count    = cnt_q;
    assign err      = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a queue scoreboard checked by a separate IM-port monitor.
module tb_instr_encoder;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, im_ready = 0;
    logic [4:0]  op_sel = 0, rs = 0, rt = 0, rd = 0;
    logic [15:0] imm = 0;
    logic [25:0] target = 0;
    logic        in_ready, im_we, err;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic [3:0]  count;

    typedef struct {
        logic [31:0] w;
        logic [9:0]  a;
    } exp_t;
    exp_t q[$];
    int next_addr = 0;
    int checks = 0, failures = 0;

    logic [4:0]  vops  [21] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11,
                               5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
    logic [31:0] vwords[21] = '{32'h00000000, 32'h00A63821, 32'h00A63823, 32'h00A63820, 32'h00A63822,
                               32'h34A600AA, 32'h3C0600AA, 32'hACA600AA, 32'h84A600AA, 32'h94A600AA,
                               32'h80A600AA, 32'h90A600AA, 32'hA4A600AA, 32'hA0A600AA, 32'h14A600AA,
                               32'h08123456, 32'h00A00008, 32'h00A03809, 32'h1CA000AA, 32'h18A000AA,
                               32'h04A000AA};

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] w);
        q.push_back('{w, next_addr[9:0]});
        next_addr++;
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high
    task automatic send(input logic [4:0] op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [15:0] i, input logic [25:0] tg, input logic [31:0] w);
        int n = 0;
        op_sel = op; rs = s; rt = t; rd = d; imm = i; target = tg; in_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        chk("send_accept", in_ready, 1);
        if (!in_ready) begin
            in_valid = 0;
            return;
        end
        if (op <= 5'd24) push_exp(w);
`ifdef ENC_DSLOT_PAD_EN
        if (op >= 5'd15 && op <= 5'd24) push_exp(32'h0);
`endif
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        in_valid = 0;
        while ((q.size() != 0 || im_we) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", {31'd0, im_we, q.size()}, 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && !flush && im_we && im_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h@%0h required=none", im_wdata, im_addr);
            end else begin
                e = q.pop_front();
                chk("im_wdata", im_wdata, e.w);
                chk("im_addr", im_addr, e.a);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_we", im_we, 0);
        chk("rst_addr", im_addr, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1 im_ready = 1;

        send(5'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221821);
        in_valid = 0;
        @(negedge clk);
        chk("first_we", im_we, 1);
        @(posedge clk); #1;
        send(5'd7, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 32'h8FA80004);
        send(5'd5, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h34011234);
        send(5'd24, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 32'h04810008);
        send(5'd18, 5'd0, 5'd0, 5'd0, 16'h0, 26'hC00, 32'h0C000C00);
        send(5'd15, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF);
        for (int k = 0; k < 21; k++) send(vops[k], 5'd5, 5'd6, 5'd7, 16'h00AA, 26'h123456, vwords[k]);
        in_valid = 0;
        @(negedge clk);
        chk("push_pop_count", count, 1);
        @(posedge clk); #1;
        wait_drain();

        im_ready = 0;
        for (int k = 0; k < 8; k++) send(5'd1, 5'(k), 5'd0, 5'd0, 16'h0, 26'h0, (32'(k) << 21) | 32'h21);
        in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("full_count", count, 8);
            chk("held_wdata", im_wdata, 32'h00000021);
        end
        @(posedge clk); #1 im_ready = 1;
        @(negedge clk);
        chk("no_push_through", in_ready, 0);
        @(posedge clk); #1;
        wait_drain();

        send(5'd27, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'h0);
        in_valid = 0;
        @(negedge clk);
        chk("err_pulse", err, 1);
        chk("err_count", count, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        @(posedge clk); #1;

        im_ready = 0;
        for (int k = 0; k < 4; k++) send(5'd1, 5'(k), 5'd0, 5'd0, 16'h0, 26'h0, (32'(k) << 21) | 32'h21);
        in_valid = 0;
        im_ready = 1;
        @(posedge clk); @(posedge clk); #1;
        im_ready = 0;
        @(negedge clk);
        chk("pre_flush_count", count, 2);
        @(posedge clk); #1;
        flush = 1; in_valid = 1; op_sel = 5'd1; im_ready = 1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        q.delete();
        next_addr = 0;
        @(posedge clk); #1 flush = 0; in_valid = 0;
        @(negedge clk);
        chk("flush_count", count, 0);
        chk("flush_we", im_we, 0);
        chk("flush_addr", im_addr, 0);
        @(posedge clk); #1;
        send(5'd1, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0, 32'h01294821);
        wait_drain();

        for (int k = 0; k < 1024; k++) send(5'd5, 5'd0, 5'd1, 5'd0, 16'(k), 26'h0, 32'h34010000 | 32'(k));
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
